// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared audio-path definitions: sample width, nominal sample
//                rate and the alarm sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W       = 32;
    localparam int SAMPLE_RATE_HZ = 48000;

    typedef enum logic [1:0] {
        ALM_IDLE   = 2'd0,
        ALM_BEEP   = 2'd1,
        ALM_SILENT = 2'd2,
        ALM_GAP    = 2'd3
    } alm_state_e;

endpackage
`default_nettype wire

// File: rtl/square_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module      : square_tone_gen
//  Description : Square-wave tone source. Tracks tone phase and the position
//                inside the current half-cycle. sample_o reflects the phase
//                that applies to the *next* sample step, so the parent can
//                register it in the same edge that updates its own state.
//  Revision    : 1.0 - initial release
// ============================================================================
module square_tone_gen
    import audio_pkg::*;
#(
    parameter int          HALF_PERIOD = 24,
    parameter logic [31:0] AMPLITUDE   = 32'd10000000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       step_i,
    input  logic                       restart_i,
    output logic signed [SAMPLE_W-1:0] sample_o
);

    localparam int HP_W = $clog2(HALF_PERIOD) + 1;

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;

    // Next phase/half-cycle position: restart wins over a step.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart_i) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (step_i) begin
            if (cnt_q == HP_W'(HALF_PERIOD - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + HP_W'(1);
            end
        end
    end

    // Phase and half-cycle counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign sample_o = phase_d ? AMPLITUDE : (~AMPLITUDE + 32'd1);

endmodule
`default_nettype wire

// File: rtl/alarm_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_tone_sequencer
//  Description : Alarm beep-pattern generator feeding the audio controller
//                output FIFO. Beep / silence cadence inside a burst, a long
//                gap between bursts, optional burst-count timeout. All
//                durations are counted in written samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_tone_sequencer
    import audio_pkg::*;
#(
    parameter logic [31:0] AMPLITUDE       = 32'd10000000,
    parameter int          HALF_PERIOD     = 24,
    parameter int          ON_SAMPLES      = 9600,
    parameter int          OFF_SAMPLES     = 9600,
    parameter int          BEEPS_PER_BURST = 3,
    parameter int          GAP_SAMPLES     = 48000,
    parameter int          MAX_BURSTS      = 0
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                start,
    input  logic                stop,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [SAMPLE_W-1:0] left_channel_audio_out,
    output logic [SAMPLE_W-1:0] right_channel_audio_out,
    output logic                alarm_active,
    output logic                timed_out,
    output logic [7:0]          burst_count
);

    localparam int MAX_OO  = (ON_SAMPLES > OFF_SAMPLES) ? ON_SAMPLES : OFF_SAMPLES;
    localparam int MAX_DUR = (MAX_OO > GAP_SAMPLES) ? MAX_OO : GAP_SAMPLES;
    localparam int DUR_W   = $clog2(MAX_DUR) + 1;
    localparam int BEEP_W  = $clog2(BEEPS_PER_BURST) + 1;

    // Zero-length durations would make the exact "== N-1" compares wrap.
    if (HALF_PERIOD <= 0 || ON_SAMPLES <= 0 || OFF_SAMPLES <= 0 ||
        GAP_SAMPLES <= 0 || BEEPS_PER_BURST <= 0) begin : g_bad_params
        $error("alarm_tone_sequencer: durations and beep count must be nonzero");
    end

    alm_state_e          state_q;
    logic [DUR_W-1:0]    dur_q;
    logic [DUR_W-1:0]    dur_lim;
    logic [BEEP_W-1:0]   beep_q;
    logic [7:0]          burst_q;
    logic                timed_out_q;
    logic                start_q;
    logic [SAMPLE_W-1:0] sample_q;

    logic                start_rise;
    logic                step;
    logic                dur_last;
    logic                beep_last;
    logic                expire;
    logic                enter_beep;
    logic                beep_next;
    logic signed [SAMPLE_W-1:0] tone_sample;

    assign alarm_active    = (state_q != ALM_IDLE);
    assign write_audio_out = alarm_active & audio_out_allowed;
    assign step            = write_audio_out;
    assign start_rise      = start & ~start_q;
    assign dur_last        = (dur_q == dur_lim);
    assign beep_last       = (beep_q == BEEP_W'(BEEPS_PER_BURST - 1));
    assign expire          = (MAX_BURSTS != 0) &&
                             (({24'd0, burst_q} + 32'd1) == 32'(MAX_BURSTS));

    // Entering BEEP restarts the tone; beep_next says the next step is a tone sample.
    assign enter_beep = ~stop & ((state_q == ALM_IDLE & start_rise) |
                        (step & dur_last & ((state_q == ALM_SILENT) |
                                            (state_q == ALM_GAP & ~expire))));
    assign beep_next  = enter_beep |
                        (~stop & (state_q == ALM_BEEP) & ~(step & dur_last));

    // Terminal count for the duration counter in the current state.
    always_comb begin
        dur_lim = DUR_W'(ON_SAMPLES - 1);
        case (state_q)
            ALM_SILENT: dur_lim = DUR_W'(OFF_SAMPLES - 1);
            ALM_GAP:    dur_lim = DUR_W'(GAP_SAMPLES - 1);
            default:    dur_lim = DUR_W'(ON_SAMPLES - 1);
        endcase
    end

    square_tone_gen #(
        .HALF_PERIOD (HALF_PERIOD),
        .AMPLITUDE   (AMPLITUDE)
    ) u_tone (
        .clk_i     (CLOCK_50),
        .rst_ni    (resetn),
        .step_i    ((state_q == ALM_BEEP) & step),
        .restart_i (enter_beep),
        .sample_o  (tone_sample)
    );

    // Pattern FSM with duration/beep/burst counters and the registered sample.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ALM_IDLE;
            dur_q       <= '0;
            beep_q      <= '0;
            burst_q     <= '0;
            timed_out_q <= 1'b0;
            start_q     <= 1'b0;
            sample_q    <= '0;
        end else begin
            start_q  <= start;
            sample_q <= beep_next ? tone_sample : '0;
            if (stop) begin
                state_q <= ALM_IDLE;
                dur_q   <= '0;
                beep_q  <= '0;
            end else begin
                case (state_q)
                    ALM_IDLE: begin
                        if (start_rise) begin
                            state_q     <= ALM_BEEP;
                            dur_q       <= '0;
                            beep_q      <= '0;
                            burst_q     <= '0;
                            timed_out_q <= 1'b0;
                        end
                    end
                    ALM_BEEP: begin
                        if (step) begin
                            if (dur_last) begin
                                dur_q   <= '0;
                                state_q <= beep_last ? ALM_GAP : ALM_SILENT;
                            end else begin
                                dur_q <= dur_q + DUR_W'(1);
                            end
                        end
                    end
                    ALM_SILENT: begin
                        if (step) begin
                            if (dur_last) begin
                                dur_q   <= '0;
                                beep_q  <= beep_q + BEEP_W'(1);
                                state_q <= ALM_BEEP;
                            end else begin
                                dur_q <= dur_q + DUR_W'(1);
                            end
                        end
                    end
                    ALM_GAP: begin
                        if (step) begin
                            if (dur_last) begin
                                dur_q   <= '0;
                                beep_q  <= '0;
                                burst_q <= (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
                                if (expire) begin
                                    state_q     <= ALM_IDLE;
                                    timed_out_q <= 1'b1;
                                end else begin
                                    state_q <= ALM_BEEP;
                                end
                            end else begin
                                dur_q <= dur_q + DUR_W'(1);
                            end
                        end
                    end
                    default: state_q <= ALM_IDLE;
                endcase
            end
        end
    end

    assign left_channel_audio_out  = sample_q;
    assign right_channel_audio_out = sample_q;
    assign timed_out               = timed_out_q;
    assign burst_count             = burst_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_tone_sequencer
//  Description : Scoreboard bench for alarm_tone_sequencer with shortened
//                pattern parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_tone_sequencer;

    localparam logic [31:0] AMP     = 32'd100;
    localparam logic [31:0] NEG_AMP = ~AMP + 32'd1;
    localparam int          HALF    = 2;
    localparam int          ON      = 4;
    localparam int          OFF     = 3;
    localparam int          BEEPS   = 2;
    localparam int          GAP     = 5;
    localparam int          MAXB    = 2;
    localparam int          BURST_LEN = BEEPS * ON + (BEEPS - 1) * OFF + GAP;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic        start;
    logic        stop;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic        alarm_active;
    logic        timed_out;
    logic [7:0]  burst_count;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_popped = 0;
    int          base;

    alarm_tone_sequencer #(
        .AMPLITUDE       (AMP),
        .HALF_PERIOD     (HALF),
        .ON_SAMPLES      (ON),
        .OFF_SAMPLES     (OFF),
        .BEEPS_PER_BURST (BEEPS),
        .GAP_SAMPLES     (GAP),
        .MAX_BURSTS      (MAXB)
    ) dut (
        .CLOCK_50                (CLOCK_50),
        .resetn                  (resetn),
        .start                   (start),
        .stop                    (stop),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .alarm_active            (alarm_active),
        .timed_out               (timed_out),
        .burst_count             (burst_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference pattern built straight from the cadence description.
    task automatic push_bursts(input int nb);
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < BEEPS; k++) begin
                for (int i = 0; i < ON; i++)
                    exp_q.push_back((((i / HALF) % 2) == 0) ? AMP : NEG_AMP);
                if (k < BEEPS - 1)
                    for (int i = 0; i < OFF; i++) exp_q.push_back(32'd0);
            end
            for (int i = 0; i < GAP; i++) exp_q.push_back(32'd0);
        end
    endtask

    task automatic wait_pops(input int target, input string tag);
        int k = 0;
        while (n_popped < target && k < 500) begin
            @(posedge CLOCK_50); #1;
            k++;
        end
        check_val(tag, 32'(n_popped), 32'(target));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_active"}, 32'(alarm_active), 32'd0);
        check_val({tag, "_write"},  32'(write_audio_out), 32'd0);
        check_val({tag, "_left"},   left_channel_audio_out, 32'd0);
        check_val({tag, "_right"},  right_channel_audio_out, 32'd0);
    endtask

    // Scoreboard: every written sample is popped and compared; stalls must not write.
    always @(negedge CLOCK_50) begin
        if (resetn && !audio_out_allowed)
            check_val("write_while_stalled", 32'(write_audio_out), 32'd0);
        if (write_audio_out) begin
            if (exp_q.size() == 0) begin
                check_val("sb_underflow", 32'(write_audio_out), 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check_val("left_sample", left_channel_audio_out, e);
                check_val("right_sample", right_channel_audio_out, e);
                n_popped++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; start = 1'b0; stop = 1'b0; audio_out_allowed = 1'b0;
        repeat (3) @(posedge CLOCK_50); #1;
        check_idle_outputs("reset");
        check_val("reset_timed_out", 32'(timed_out), 32'd0);
        check_val("reset_burst_count", 32'(burst_count), 32'd0);
        resetn = 1'b1;
        @(posedge CLOCK_50); #1;

        // Full pattern to timeout with the FIFO always ready.
        audio_out_allowed = 1'b1;
        push_bursts(MAXB);
        pulse_start();
        check_val("started_active", 32'(alarm_active), 32'd1);
        wait_pops(BURST_LEN, "burst1_pops");
        check_val("burst1_count", 32'(burst_count), 32'd1);
        check_val("burst1_still_active", 32'(alarm_active), 32'd1);
        wait_pops(2 * BURST_LEN, "burst2_pops");
        check_val("expiry_active", 32'(alarm_active), 32'd0);
        check_val("expiry_timed_out", 32'(timed_out), 32'd1);
        check_val("expiry_burst_count", 32'(burst_count), 32'd2);
        check_val("expiry_write", 32'(write_audio_out), 32'd0);

        // Same pattern again under random back-pressure.
        base = n_popped;
        push_bursts(MAXB);
        pulse_start();
        check_val("restart_timed_out_clr", 32'(timed_out), 32'd0);
        check_val("restart_burst_count", 32'(burst_count), 32'd0);
        for (int k = 0; k < 3000 && n_popped < base + 2 * BURST_LEN; k++) begin
            audio_out_allowed = 1'($urandom_range(0, 1));
            @(posedge CLOCK_50); #1;
        end
        check_val("stall_run_pops", 32'(n_popped), 32'(base + 2 * BURST_LEN));
        audio_out_allowed = 1'b1;
        check_val("stall_timed_out", 32'(timed_out), 32'd1);
        check_val("stall_burst_count", 32'(burst_count), 32'd2);

        // Stop on the second beep sample; start together with stop stays idle.
        base = n_popped;
        exp_q.push_back(AMP);
        exp_q.push_back(AMP);
        pulse_start();
        wait_pops(base + 1, "stop_first_sample");
        stop = 1'b1;
        @(posedge CLOCK_50); #1;
        check_idle_outputs("after_stop");
        check_val("stop_pops", 32'(n_popped), 32'(base + 2));
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        check_val("start_with_stop", 32'(alarm_active), 32'd0);
        stop = 1'b0;
        @(posedge CLOCK_50); #1;
        check_val("held_start_no_edge", 32'(alarm_active), 32'd0);
        start = 1'b0;
        @(posedge CLOCK_50); #1;

        // Second start mid-SILENT is ignored; reset mid-BEEP clears everything.
        base = n_popped;
        push_bursts(1);
        pulse_start();
        wait_pops(base + ON + 1, "silent_reached");
        pulse_start();
        wait_pops(base + ON + OFF + 2, "beep2_reached");
        #1 resetn = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        check_val("async_reset_burst", 32'(burst_count), 32'd0);
        check_val("sb_remaining", 32'(exp_q.size()), 32'(BURST_LEN - (ON + OFF + 2)));
        exp_q.delete();
        @(posedge CLOCK_50); #1;
        resetn = 1'b1;
        @(posedge CLOCK_50); #1;
        check_val("post_reset_active", 32'(alarm_active), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
